// File: rtl/audio_dac_feeder_if.sv
// ----------------------------------------------------------------------------
// audio_dac_feeder_if
// Groups the PCM sample stream (valid/ready) and the DAC FIFO write side that
// pass through audio_dac_feeder.
//
// Signals:
//   in_valid   sample valid from the upstream source
//   in_ready   feeder can take the presented sample
//   in_data    two's-complement PCM sample (SAMPLE_WIDTH bits)
//   in_left    1 = left-channel sample, 0 = right
//   write      FIFO write strobe
//   writedata  packed {left, right} word (DATA_WIDTH bits)
//   full       DAC FIFO full flag
//
// Modports:
//   slave   the feeder's view (consumes samples, drives the FIFO write side)
//   master  the surroundings' view (sample source plus FIFO)
// ----------------------------------------------------------------------------
interface audio_dac_feeder_if #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int DATA_WIDTH   = 32
) ();

   logic                    in_valid;
   logic                    in_ready;
   logic [SAMPLE_WIDTH-1:0] in_data;
   logic                    in_left;
   logic                    write;
   logic [DATA_WIDTH-1:0]   writedata;
   logic                    full;

   modport slave (
      input  in_valid,
      output in_ready,
      input  in_data,
      input  in_left,
      output write,
      output writedata,
      input  full
   );

   modport master (
      output in_valid,
      input  in_ready,
      output in_data,
      output in_left,
      input  write,
      input  writedata,
      output full
   );

endinterface

// File: rtl/audio_dac_feeder.sv
// ----------------------------------------------------------------------------
// audio_dac_feeder
// Pairs a tagged left/right PCM sample stream into {left, right} words and
// writes them into the DAC FIFO. Left sits in the upper half because the DAC
// serialiser shifts MSB-first starting on the left phase. Misaligned samples
// are counted, mute zeroes completed words, and flush discards the pairing
// and holding state while keeping the counters.
//
// Ports:
//   clk            system clock (same as the DAC FIFO write side)
//   reset_n        synchronous, active-low reset
//   bus            audio_dac_feeder_if.slave: sample stream + FIFO write side
//   mute           forces completed words to zero (sampled on right accept)
//   flush          synchronous flush of pairing/holding state
//   vol_atten      (AUDIO_DAC_FEEDER_VOLUME_EN only) arithmetic right-shift
//                  applied to both channels on right accept
//   words_written  wrapping count of FIFO writes
//   align_errors   saturating count of misalignment events
//
// Optional feature macro: AUDIO_DAC_FEEDER_VOLUME_EN
// ----------------------------------------------------------------------------
module audio_dac_feeder #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int DATA_WIDTH   = 32,
   parameter int ERR_WIDTH    = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   audio_dac_feeder_if.slave     bus,
   input  logic                  mute,
   input  logic                  flush,
`ifdef AUDIO_DAC_FEEDER_VOLUME_EN
   input  logic [3:0]            vol_atten,
`endif
   output logic [15:0]           words_written,
   output logic [ERR_WIDTH-1:0]  align_errors
);

   localparam logic [0:0] WAIT_L = 1'b0;
   localparam logic [0:0] HAVE_L = 1'b1;

   logic [0:0]              state_r,  state_s;
   logic                    hold_valid_r, hold_valid_s;
   logic [SAMPLE_WIDTH-1:0] left_reg_r, left_reg_s;
   logic [DATA_WIDTH-1:0]   hold_reg_r, hold_reg_s;
   logic [15:0]             words_r;
   logic [ERR_WIDTH-1:0]    errs_r;

   logic                    in_ready_s;
   logic                    accept_s;
   logic                    write_s;
   logic                    err_inc_s;
   logic [SAMPLE_WIDTH-1:0] left_adj_s;
   logic [SAMPLE_WIDTH-1:0] right_adj_s;
   logic [DATA_WIDTH-1:0]   pair_s;

`ifdef AUDIO_DAC_FEEDER_VOLUME_EN
   // Sign-preserving attenuation; shifts at or beyond the width give all sign bits.
   function automatic logic [SAMPLE_WIDTH-1:0] attenuate(
      input logic [SAMPLE_WIDTH-1:0] sample,
      input logic [3:0]              shift
   );
      attenuate = $unsigned($signed(sample) >>> shift);
   endfunction
`endif

   // Handshake and write strobe: in_ready depends only on registered state, never on full.
   always_comb begin
      in_ready_s = 1'b0;
      write_s    = 1'b0;
      if (reset_n) begin
         in_ready_s = (state_r == WAIT_L) || !hold_valid_r;
         write_s    = !flush && hold_valid_r && !bus.full;
      end else begin
         in_ready_s = 1'b0;
         write_s    = 1'b0;
      end
   end

   assign accept_s      = bus.in_valid && in_ready_s;
   assign bus.in_ready  = in_ready_s;
   assign bus.write     = write_s;
   assign bus.writedata = hold_reg_r;
   assign words_written = words_r;
   assign align_errors  = errs_r;

   // Channel conditioning and packing of the word formed on a right accept.
   always_comb begin
`ifdef AUDIO_DAC_FEEDER_VOLUME_EN
      left_adj_s  = attenuate(left_reg_r, vol_atten);
      right_adj_s = attenuate(bus.in_data, vol_atten);
`else
      left_adj_s  = left_reg_r;
      right_adj_s = bus.in_data;
`endif
      if (mute) begin
         pair_s = {DATA_WIDTH{1'b0}};
      end else begin
         pair_s = {left_adj_s, right_adj_s};
      end
   end

   // Pairing FSM next state; flush overrides any accept or write this cycle.
   always_comb begin
      state_s      = state_r;
      hold_valid_s = hold_valid_r;
      left_reg_s   = left_reg_r;
      hold_reg_s   = hold_reg_r;
      err_inc_s    = 1'b0;
      if (flush) begin
         state_s      = WAIT_L;
         hold_valid_s = 1'b0;
         left_reg_s   = {SAMPLE_WIDTH{1'b0}};
      end else begin
         if (write_s) begin
            hold_valid_s = 1'b0;
         end else begin
            hold_valid_s = hold_valid_r;
         end
         if (accept_s) begin
            case (state_r)
               WAIT_L: begin
                  if (bus.in_left) begin
                     left_reg_s = bus.in_data;
                     state_s    = HAVE_L;
                  end else begin
                     err_inc_s  = 1'b1;   // orphan right sample is dropped
                  end
               end
               HAVE_L: begin
                  if (bus.in_left) begin
                     left_reg_s = bus.in_data;   // newer left replaces the stale one
                     err_inc_s  = 1'b1;
                  end else begin
                     hold_reg_s   = pair_s;
                     hold_valid_s = 1'b1;
                     state_s      = WAIT_L;
                  end
               end
               default: begin
                  state_s = WAIT_L;
               end
            endcase
         end else begin
            state_s = state_r;
         end
      end
   end

   // State, holding register and counters.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r      <= WAIT_L;
         hold_valid_r <= 1'b0;
         left_reg_r   <= {SAMPLE_WIDTH{1'b0}};
         hold_reg_r   <= {DATA_WIDTH{1'b0}};
         words_r      <= 16'd0;
         errs_r       <= {ERR_WIDTH{1'b0}};
      end else begin
         state_r      <= state_s;
         hold_valid_r <= hold_valid_s;
         left_reg_r   <= left_reg_s;
         hold_reg_r   <= hold_reg_s;
         if (write_s) begin
            words_r <= words_r + 16'd1;
         end else begin
            words_r <= words_r;
         end
         if (err_inc_s && (errs_r != {ERR_WIDTH{1'b1}})) begin
            errs_r <= errs_r + {{(ERR_WIDTH-1){1'b0}}, 1'b1};
         end else begin
            errs_r <= errs_r;
         end
      end
   end

endmodule

// File: tb/tb_audio_dac_feeder.sv
// ----------------------------------------------------------------------------
// tb_audio_dac_feeder
// Directed bench for audio_dac_feeder. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. Every FIFO write seen
// on a falling edge is captured in wq and checked against hand-computed words.
// ----------------------------------------------------------------------------
module tb_audio_dac_feeder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mute;
   logic        flush;
   logic [15:0] words_written;
   logic [7:0]  align_errors;
`ifdef AUDIO_DAC_FEEDER_VOLUME_EN
   logic [3:0]  vol_atten;
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] wq[$];

   always #5 clk = ~clk;

   audio_dac_feeder_if #(.SAMPLE_WIDTH(16), .DATA_WIDTH(32)) bus ();

   audio_dac_feeder #(.SAMPLE_WIDTH(16), .DATA_WIDTH(32), .ERR_WIDTH(8)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .bus           (bus),
      .mute          (mute),
      .flush         (flush),
`ifdef AUDIO_DAC_FEEDER_VOLUME_EN
      .vol_atten     (vol_atten),
`endif
      .words_written (words_written),
      .align_errors  (align_errors)
   );

   // Capture every FIFO write.
   always @(negedge clk) begin
      if (bus.write === 1'b1) wq.push_back(bus.writedata);
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one sample and hold it until accepted (bounded wait).
   task automatic send(input logic left, input logic [15:0] d);
      int waited = 0;
      bit done   = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_left  = left;
      bus.in_data  = d;
      while (!done) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) begin
            tick();
            done = 1'b1;
         end else if (waited >= 50) begin
            check_eq("send_timeout", {31'd0, bus.in_ready}, 32'd1);
            tick();
            done = 1'b1;
         end else begin
            waited++;
            tick();
         end
      end
      bus.in_valid = 1'b0;
   endtask

   // Check the captured write list has exactly one word, then clear it.
   task automatic expect_one(input string tag, input logic [31:0] exp);
      check_eq({tag, "_count"}, wq.size(), 32'd1);
      if (wq.size() > 0) check_eq({tag, "_data"}, wq[0], exp);
      wq.delete();
   endtask

   initial begin
      reset_n      = 1'b0;
      mute         = 1'b0;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_left  = 1'b0;
      bus.in_data  = 16'h0000;
      bus.full     = 1'b0;
`ifdef AUDIO_DAC_FEEDER_VOLUME_EN
      vol_atten    = 4'd0;
`endif
      tick(); tick(); tick();

      // Reset state
      @(negedge clk);
      check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check_eq("rst_write",    {31'd0, bus.write},    32'd0);
      check_eq("rst_words",    {16'd0, words_written}, 32'd0);
      check_eq("rst_errs",     {24'd0, align_errors},  32'd0);
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);
      tick();

      // Basic pairing: write appears the cycle after the right accept
      send(1'b1, 16'h1234);
      send(1'b0, 16'hABCD);
      @(negedge clk);
      check_eq("basic_write", {31'd0, bus.write}, 32'd1);
      check_eq("basic_wdata", bus.writedata, 32'h1234ABCD);
      tick();
      expect_one("basic", 32'h1234ABCD);
      check_eq("basic_words", {16'd0, words_written}, 32'd1);

      // Back-pressure with full held high
      bus.full = 1'b1;
      send(1'b1, 16'h0001);
      send(1'b0, 16'h0002);
      send(1'b1, 16'h0003);
      for (int i = 0; i < 17; i++) tick();
      @(negedge clk);
      check_eq("bp_write",    {31'd0, bus.write},    32'd0);
      check_eq("bp_wdata",    bus.writedata,         32'h00010002);
      check_eq("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      bus.full = 1'b0;
      send(1'b0, 16'h0004);
      tick();
      check_eq("bp_count", wq.size(), 32'd2);
      if (wq.size() == 2) begin
         check_eq("bp_first",  wq[0], 32'h00010002);
         check_eq("bp_second", wq[1], 32'h00030004);
      end
      wq.delete();
      check_eq("bp_words", {16'd0, words_written}, 32'd3);

      // Misalignment: orphan right, doubled left
      send(1'b0, 16'h5555);
      send(1'b1, 16'h1111);
      send(1'b1, 16'h2222);
      send(1'b0, 16'h3333);
      tick();
      check_eq("mis_errs", {24'd0, align_errors}, 32'd2);
      expect_one("mis", 32'h22223333);

      // Saturation of the error counter
      for (int i = 0; i < 300; i++) send(1'b0, i[15:0]);
      check_eq("mis_sat", {24'd0, align_errors}, 32'd255);
      check_eq("mis_sat_nowrite", wq.size(), 32'd0);

      // Mute on the right accept zeroes the word
      send(1'b1, 16'h7FFF);
      mute = 1'b1;
      send(1'b0, 16'h8000);
      mute = 1'b0;
      tick();
      expect_one("mute", 32'h00000000);

      // Mute raised after the word is held does not alter it
      bus.full = 1'b1;
      send(1'b1, 16'h0101);
      send(1'b0, 16'h0202);
      mute = 1'b1;
      tick(); tick();
      bus.full = 1'b0;
      tick(); tick();
      mute = 1'b0;
      expect_one("mute_held", 32'h01010202);
      check_eq("mute_words", {16'd0, words_written}, 32'd6);

      // Flush in HAVE_L with a held word: no write, back to WAIT_L
      bus.full = 1'b1;
      send(1'b1, 16'hAAAA);
      send(1'b0, 16'hBBBB);
      send(1'b1, 16'hCCCC);
      flush    = 1'b1;
      bus.full = 1'b0;
      @(negedge clk);
      check_eq("flush_write", {31'd0, bus.write}, 32'd0);
      tick();
      flush = 1'b0;
      @(negedge clk);
      check_eq("flush_write_after", {31'd0, bus.write}, 32'd0);
      check_eq("flush_in_ready",    {31'd0, bus.in_ready}, 32'd1);
      check_eq("flush_words",       {16'd0, words_written}, 32'd6);
      check_eq("flush_errs",        {24'd0, align_errors}, 32'd255);
      tick();
      send(1'b0, 16'h0DDD);   // would complete a pair if the left had survived
      tick();
      check_eq("flush_nowrite", wq.size(), 32'd0);
      send(1'b1, 16'h1010);
      send(1'b0, 16'h2020);
      tick();
      expect_one("post_flush", 32'h10102020);
      check_eq("post_flush_words", {16'd0, words_written}, 32'd7);

      // Reset while a word is about to be written
      send(1'b1, 16'h4242);
      send(1'b0, 16'h2424);
      reset_n = 1'b0;
      @(negedge clk);
      check_eq("mrst_write",    {31'd0, bus.write},    32'd0);
      check_eq("mrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      check_eq("mrst_words", {16'd0, words_written}, 32'd0);
      check_eq("mrst_errs",  {24'd0, align_errors},  32'd0);
      tick();
      check_eq("mrst_nowrite", wq.size(), 32'd0);
      send(1'b1, 16'h1357);
      send(1'b0, 16'h2468);
      tick();
      expect_one("mrst_pair", 32'h13572468);
      check_eq("mrst_words_after", {16'd0, words_written}, 32'd1);

`ifdef AUDIO_DAC_FEEDER_VOLUME_EN
      // Volume attenuation by 2
      vol_atten = 4'd2;
      send(1'b1, 16'h8000);
      send(1'b0, 16'h0100);
      vol_atten = 4'd0;
      tick();
      expect_one("vol", 32'hE0000040);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
